// File: rtl/myproject_dense_acc.sv
// myproject_dense_acc: accumulate N_IN signed products on top of a bias, then
// round (half toward +inf), arithmetic-shift by FRAC_SHIFT and saturate to
// OUT_WIDTH signed. The result is offered on a valid/ready handshake.
// Optional build macro: MYPROJECT_ACC_RELU_EN clamps negative results to zero.
module myproject_dense_acc #(
  parameter int PROD_WIDTH = 22,
  parameter int OUT_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int N_IN       = 16,
  parameter int FRAC_SHIFT = 5
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic                         prod_last,
  input  logic signed [OUT_WIDTH-1:0]  bias_in,
  output logic signed [OUT_WIDTH-1:0]  res_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_ovf,
  output logic                         err,
  output logic                         busy
);

  localparam int CNT_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_IN - 1);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HALF    = RW'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] OUT_MAX = (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] OUT_MIN = -(RW'(1) <<< (OUT_WIDTH - 1));

  typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

  state_t                        state_reg;
  logic [CNT_WIDTH-1:0]          cnt_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;

  logic                          beat;
  logic                          cnt_is_last;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [RW-1:0]          rnd_sum;
  logic signed [RW-1:0]          rnd_q;
  logic signed [OUT_WIDTH-1:0]   sat_data;
  logic                          sat_ovf;

  assign beat        = prod_valid && prod_ready;
  assign cnt_is_last = (cnt_reg == CNT_LAST);

  // Sign-extend the product; the bias is pre-scaled into accumulator units.
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_in[OUT_WIDTH-1]}}, bias_in} <<< FRAC_SHIFT;

  // Round half toward +inf: add half an LSB, then floor via arithmetic shift.
  assign rnd_sum = {acc_reg[ACC_WIDTH-1], acc_reg} + HALF;
  assign rnd_q   = rnd_sum >>> FRAC_SHIFT;

  // busy covers a partially accumulated vector and any pending result.
  assign busy = (state_reg != S_ACC) || (cnt_reg != '0);

  // Saturate the rounded value into the output range.
  always_comb begin
    sat_data = rnd_q[OUT_WIDTH-1:0];
    sat_ovf  = 1'b0;
    if (rnd_q > OUT_MAX) begin
      sat_data = OUT_MAX[OUT_WIDTH-1:0];
      sat_ovf  = 1'b1;
`ifdef MYPROJECT_ACC_RELU_EN
    end else if (rnd_q[RW-1]) begin
      sat_data = '0;
      sat_ovf  = 1'b0;
`else
    end else if (rnd_q < OUT_MIN) begin
      sat_data = OUT_MIN[OUT_WIDTH-1:0];
      sat_ovf  = 1'b1;
`endif
    end
  end

  // Control FSM, accumulator, result register and sticky framing flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg  <= S_ACC;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      res_ovf    <= 1'b0;
      err        <= 1'b0;
      prod_ready <= 1'b0;
    end else begin
      case (state_reg)
        S_ACC: begin
          // Ready comes up one cycle after reset and drops after the last beat.
          prod_ready <= !(beat && cnt_is_last);
          if (beat) begin
            if (cnt_reg == '0) acc_reg <= bias_ext + prod_ext;
            else               acc_reg <= acc_reg + prod_ext;
            // prod_last is only cross-checked; the count alone ends the vector.
            if (prod_last != cnt_is_last) err <= 1'b1;
            if (cnt_is_last) begin
              cnt_reg   <= '0;
              state_reg <= S_FIN;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        S_FIN: begin
          res_data   <= sat_data;
          res_ovf    <= sat_ovf;
          res_valid  <= 1'b1;
          prod_ready <= 1'b0;
          state_reg  <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            prod_ready <= 1'b1;
            state_reg  <= S_ACC;
          end
        end
        default: begin
          state_reg  <= S_ACC;
          prod_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
